// File: rtl/stdp_train_supervisor.sv
// stdp_train_supervisor: gates STDP/pulse enables per training session, stopping on a spike-count limit or a cycle budget.
module stdp_train_supervisor #(
    parameter int NUM_CH = 10,
    parameter int ADDR_W = 6,
    parameter logic [ADDR_W-1:0] MATCH_ADDR = 6'h30,
    parameter int CNT_W = 4,
    parameter int PULSE_W = 17,
    parameter int TMO_W = 20,
    localparam int WIN_W = $clog2(NUM_CH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [NUM_CH-1:0]         ch_sel_i,
    input  logic [CNT_W-1:0]          spike_limit_i,
    input  logic [TMO_W-1:0]          max_cycles_i,
    input  logic [NUM_CH*ADDR_W-1:0]  addr_i,
    input  logic [PULSE_W-1:0]        pulse_i,
    output logic                      en_stdp_o,
    output logic                      en_pulse_o,
    output logic [PULSE_W-1:0]        pulse_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [WIN_W-1:0]          winner_o,
    output logic [NUM_CH*CNT_W-1:0]   cnt_vec_o
);
    typedef enum logic [1:0] {IDLE, TRAIN, FIN} state_t;
    state_t                    state_q;
    logic [NUM_CH-1:0]         prev_q, sel_q, match, evt, hit, mask;
    logic [NUM_CH*CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]          lim_q;
    logic [TMO_W-1:0]          max_q, cyc_q;
    logic                      mode_q, done_q, timeout_q, stop, tmo;
    logic [WIN_W-1:0]          winner_q, win_d;
    // mode 1 treats every channel as a target, so one lowest-index search serves both modes
    always_comb begin
        mask = mode_q ? '1 : sel_q;
        win_d = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            match[i] = addr_i[i*ADDR_W +: ADDR_W] == MATCH_ADDR;
            evt[i] = match[i] & ~prev_q[i];
            cnt_d[i*CNT_W +: CNT_W] = (evt[i] && cnt_q[i*CNT_W +: CNT_W] != '1) ?
                cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1) : cnt_q[i*CNT_W +: CNT_W];
            hit[i] = mask[i] && ({1'b0, cnt_q[i*CNT_W +: CNT_W]} + (CNT_W+1)'(evt[i])) >= {1'b0, lim_q};
            win_d = hit[i] ? WIN_W'(i) : win_d;
        end
    end
    assign stop = |hit;
    assign tmo = max_q != '0 && cyc_q == max_q - TMO_W'(1);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            cnt_q     <= '0;
            cyc_q     <= '0;
            mode_q    <= 1'b0;
            sel_q     <= '0;
            lim_q     <= '0;
            max_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            winner_q  <= '0;
        end else begin
            prev_q <= match;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    state_q   <= TRAIN;
                    mode_q    <= mode_i;
                    sel_q     <= ch_sel_i;
                    lim_q     <= spike_limit_i == '0 ? CNT_W'(1) : spike_limit_i;
                    max_q     <= max_cycles_i;
                    cnt_q     <= '0;
                    cyc_q     <= '0;
                    timeout_q <= 1'b0;
                    winner_q  <= '0;
                end
                TRAIN: begin
                    cnt_q <= cnt_d;
                    cyc_q <= cyc_q + TMO_W'(1);
                    if (stop || tmo) begin
                        state_q   <= FIN;
                        done_q    <= 1'b1;
                        timeout_q <= ~stop;
                        winner_q  <= stop ? win_d : winner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o     = state_q == TRAIN;
    assign en_stdp_o  = busy_o;
    assign en_pulse_o = busy_o;
    assign pulse_o    = en_pulse_o ? pulse_i : '0;
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;
    assign winner_o   = winner_q;
    assign cnt_vec_o  = cnt_q;
endmodule
